// File: rtl/seq_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_frame_tx
// Brief    : Serial frame transmitter: sync preamble, MSB-first payload, idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module seq_frame_tx #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               DATA_W  = 8,
  parameter int               GAP     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              x,
  output logic              tx_active,
  output logic              done,
  output logic [7:0]        frame_cnt
);

  localparam int c_max_a   = (PAT_W > DATA_W) ? PAT_W : DATA_W;
  localparam int c_max_b   = (c_max_a > GAP) ? c_max_a : GAP;
  localparam int c_max_len = (c_max_b > 1) ? c_max_b : 1;
  localparam int c_cnt_w   = (c_max_len <= 1) ? 1 : $clog2(c_max_len);

  localparam logic [c_cnt_w-1:0] c_pre_ld  = c_cnt_w'(PAT_W - 1);
  localparam logic [c_cnt_w-1:0] c_data_ld = c_cnt_w'(DATA_W - 1);
  localparam logic [c_cnt_w-1:0] c_gap_ld  = c_cnt_w'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAPS = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [DATA_W-1:0]   r_sh;
  logic [PAT_W-1:0]    r_pre;

  assign in_ready = (r_state == ST_IDLE);

  // x always holds the bit of the current cycle, so each branch loads the
  // bit that belongs to the cycle following the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sh      <= '0;
      r_pre     <= '0;
      x         <= 1'b0;
      tx_active <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sh      <= in_data;
            r_pre     <= PATTERN << 1;
            r_cnt     <= c_pre_ld;
            x         <= PATTERN[PAT_W-1];
            tx_active <= 1'b1;
            r_state   <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (r_cnt == '0) begin
            r_cnt   <= c_data_ld;
            x       <= r_sh[DATA_W-1];
            r_sh    <= r_sh << 1;
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            x     <= r_pre[PAT_W-1];
            r_pre <= r_pre << 1;
          end
        end
        ST_DATA: begin
          if (r_cnt == '0) begin
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
            x         <= 1'b0;
            if (GAP > 0) begin
              r_cnt   <= c_gap_ld;
              r_state <= ST_GAPS;
            end else begin
              tx_active <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
            x     <= r_sh[DATA_W-1];
            r_sh  <= r_sh << 1;
          end
        end
        ST_GAPS: begin
          x <= 1'b0;
          if (r_cnt == '0) begin
            tx_active <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          x         <= 1'b0;
          tx_active <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_frame_tx
// Brief    : Self-checking bench for seq_frame_tx (default and short configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, x, tx_active, done;
  logic [7:0] frame_cnt;

  logic       s_valid;
  logic [3:0] s_data;
  logic       s_ready, s_x, s_act, s_done;
  logic [7:0] s_fc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_frame_tx dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .x(x), .tx_active(tx_active), .done(done),
    .frame_cnt(frame_cnt)
  );

  seq_frame_tx #(.PAT_W(3), .PATTERN(3'b110), .DATA_W(4), .GAP(0)) dut_s (
    .clk(clk), .reset(reset), .in_valid(s_valid), .in_data(s_data),
    .in_ready(s_ready), .x(s_x), .tx_active(s_act), .done(s_done),
    .frame_cnt(s_fc)
  );

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       ex;
    logic       ea;
    logic       ed;
    logic       er;
    logic [7:0] ef;
  } vec_t;

  vec_t tbl [32];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Offers one word in an IDLE cycle and checks the whole 14-bit frame.
  task automatic send_frame(input logic [7:0] d, input logic [13:0] bits,
                            input logic [7:0] fc_exp);
    @(negedge clk);
    chk1("pre_accept_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      chk1("frame_x", x, bits[14-k]);
      chk1("frame_active", tx_active, 1'b1);
      chk1("frame_done", done, (k == 13));
      @(negedge clk);
    end
    chk1("post_active", tx_active, 1'b0);
    chk1("post_ready", in_ready, 1'b1);
    chk8("post_frame_cnt", frame_cnt, fc_exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [13:0] fa5;
    logic [13:0] fff;
    logic [6:0]  fs;
    logic [3:0]  win;
    int ndone, ndet, nbad, pos, cyc;

    fa5 = 14'b10111010010100;
    fff = 14'b10111111111100;
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    for (int i = 1; i <= 14; i++)
      tbl[i] = '{1'b1, 8'hFF, fa5[14-i], 1'b1, (i == 13), 1'b0, (i >= 13) ? 8'd1 : 8'd0};
    tbl[15] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    for (int i = 16; i <= 29; i++)
      tbl[i] = '{1'b0, 8'h00, fff[29-i], 1'b1, (i == 28), 1'b0, (i >= 28) ? 8'd2 : 8'd1};
    tbl[30] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[31] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    s_valid  = 1'b0;
    s_data   = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_x", x, 1'b0);
    chk1("rst_active", tx_active, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ready", in_ready, 1'b1);
    chk8("rst_frame_cnt", frame_cnt, 8'd0);
    reset = 1'b0;

    // A5 frame with FF held on the input, then FF accepted in the first IDLE cycle
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk1("tbl_x", x, tbl[i].ex);
      chk1("tbl_active", tx_active, tbl[i].ea);
      chk1("tbl_done", done, tbl[i].ed);
      chk1("tbl_ready", in_ready, tbl[i].er);
      chk8("tbl_frame_cnt", frame_cnt, tbl[i].ef);
      in_valid = tbl[i].vld;
      in_data  = tbl[i].dat;
    end

    // Asynchronous reset in the middle of payload bit 3
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk1("midframe_x", x, 1'b1);
    chk1("midframe_active", tx_active, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("async_rst_x", x, 1'b0);
    chk1("async_rst_active", tx_active, 1'b0);
    chk1("async_rst_done", done, 1'b0);
    chk1("async_rst_ready", in_ready, 1'b1);
    chk8("async_rst_frame_cnt", frame_cnt, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    send_frame(8'h3C, 14'b10110011110000, 8'd1);

    // 256 back-to-back frames with a bench-side 1011 detector on x
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    ndone = 0; ndet = 0; nbad = 0; pos = 0; win = 4'b0000; cyc = 0;
    while (ndone < 256 && cyc < 256 * 15 + 40) begin
      @(negedge clk);
      cyc++;
      pos = tx_active ? pos + 1 : 0;
      win = {win[2:0], x};
      if (win == 4'b1011) begin
        ndet++;
        if (pos != 4) nbad++;
      end
      if (done) begin
        ndone++;
        if (ndone == 255) chk8("wrap_cnt_255", frame_cnt, 8'd255);
        if (ndone == 256) chk8("wrap_cnt_0", frame_cnt, 8'd0);
      end
    end
    in_valid = 1'b0;
    chk8("wrap_done_count", 8'(ndone), 8'(256 % 256));
    chk1("wrap_done_reached", (ndone == 256), 1'b1);
    chk1("detect_count", (ndet == 256), 1'b1);
    chk1("detect_position", (nbad == 0), 1'b1);

    // Short configuration: PAT_W=3, PATTERN=110, DATA_W=4, GAP=0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fs = 7'b1101001;
    @(negedge clk);
    chk1("s_ready_idle", s_ready, 1'b1);
    s_valid = 1'b1;
    s_data  = 4'h9;
    @(negedge clk);
    s_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      chk1("s_x", s_x, fs[7-k]);
      chk1("s_active", s_act, 1'b1);
      chk1("s_done_early", s_done, 1'b0);
      @(negedge clk);
    end
    chk1("s_idle_x", s_x, 1'b0);
    chk1("s_idle_active", s_act, 1'b0);
    chk1("s_idle_done", s_done, 1'b1);
    chk1("s_idle_ready", s_ready, 1'b1);
    chk8("s_frame_cnt", s_fc, 8'd1);
    @(negedge clk);
    chk1("s_done_single", s_done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
